// File: rtl/dmem_port_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module : dmem_port_arbiter_pkg
// Brief  : Shared encodings and defaults for the data-memory port arbiter.
// Rev    : 1.0  initial release
// ============================================================================
package dmem_port_arbiter_pkg;

    localparam logic [1:0] D_IDLE = 2'd0;
    localparam logic [1:0] D_WAIT = 2'd1;
    localparam logic [1:0] D_ACK  = 2'd2;

    localparam int unsigned MEM_BYTES_DEFAULT = 128;

endpackage
`default_nettype wire

// File: rtl/dmem_addr_check.sv
`default_nettype none
// ============================================================================
// Module : dmem_addr_check
// Brief  : Combinational word-access legality test (alignment and range).
// Rev    : 1.0  initial release
// ============================================================================
module dmem_addr_check
    import dmem_port_arbiter_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int MEM_BYTES = MEM_BYTES_DEFAULT
) (
    input  logic [DATA_W-1:0] addr,
    output logic              legal
);

    // Highest byte address at which a whole word still fits in memory.
    localparam logic [DATA_W-1:0] LAST_WORD = DATA_W'(MEM_BYTES - 4);

    assign legal = (addr[1:0] == 2'b00) && (addr <= LAST_WORD);

endmodule
`default_nettype wire

// File: rtl/dmem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module : dmem_port_arbiter
// Brief  : Shares one data-memory port between the CPU MEM stage (priority)
//          and a req/ack debug port protected by a starvation counter.
// Rev    : 1.0  initial release
// ============================================================================
module dmem_port_arbiter
    import dmem_port_arbiter_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int MEM_BYTES  = MEM_BYTES_DEFAULT,
    parameter int STARVE_MAX = 4,
    parameter int CNT_W      = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cpu_read,
    input  logic              cpu_write,
    input  logic [DATA_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_stall,
    output logic              cpu_err,
    input  logic              dbg_req,
    input  logic              dbg_we,
    input  logic [DATA_W-1:0] dbg_addr,
    input  logic [DATA_W-1:0] dbg_wdata,
    output logic              dbg_ack,
    output logic [DATA_W-1:0] dbg_rdata,
    output logic              dbg_err,
    output logic [DATA_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_read,
    output logic              mem_write,
    input  logic [DATA_W-1:0] mem_rdata
);

    logic [1:0]        r_state;
    logic [1:0]        w_state_next;
    logic [CNT_W-1:0]  r_starve_cnt;
    logic [DATA_W-1:0] r_dbg_rdata;
    logic              r_dbg_err;
    logic              w_dbg_elig;
    logic              w_cpu_req;
    logic              w_starved;
    logic              w_dbg_gnt;
    logic              w_cpu_gnt;
    logic              w_cpu_legal;
    logic              w_dbg_legal;

    dmem_addr_check #(.DATA_W(DATA_W), .MEM_BYTES(MEM_BYTES)) u_cpu_check (
        .addr  (cpu_addr),
        .legal (w_cpu_legal)
    );

    dmem_addr_check #(.DATA_W(DATA_W), .MEM_BYTES(MEM_BYTES)) u_dbg_check (
        .addr  (dbg_addr),
        .legal (w_dbg_legal)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= D_IDLE;
        else        r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            D_IDLE:  if (dbg_req) w_state_next = w_dbg_gnt ? D_ACK : D_WAIT;
            D_WAIT:  if (w_dbg_gnt) w_state_next = D_ACK;
            D_ACK:   w_state_next = D_IDLE;
            default: w_state_next = D_IDLE;
        endcase
    end

    // The ack cycle is never eligible, so a held dbg_req restarts from D_IDLE.
    always_comb begin
        w_dbg_elig = 1'b0;
        dbg_ack    = 1'b0;
        case (r_state)
            D_IDLE:  w_dbg_elig = dbg_req;
            D_WAIT:  w_dbg_elig = 1'b1;
            D_ACK:   dbg_ack    = rst_n;
            default: w_dbg_elig = 1'b0;
        endcase
    end

    assign w_cpu_req = cpu_read | cpu_write;
    assign w_starved = (r_starve_cnt == CNT_W'(STARVE_MAX));
    assign w_dbg_gnt = rst_n & w_dbg_elig & (~w_cpu_req | w_starved);
    assign w_cpu_gnt = rst_n & w_cpu_req & ~w_dbg_gnt;

    always_ff @(posedge clk) begin
        if (!rst_n)                       r_starve_cnt <= '0;
        else if (w_dbg_gnt)               r_starve_cnt <= '0;
        else if (w_dbg_elig && !w_starved) r_starve_cnt <= r_starve_cnt + 1'b1;
    end

    // Illegal accesses still consume the grant but never touch memory.
    always_comb begin
        mem_addr  = '0;
        mem_wdata = '0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        cpu_rdata = '0;
        cpu_err   = 1'b0;
        cpu_stall = 1'b0;
        if (w_cpu_gnt) begin
            mem_addr  = cpu_addr;
            mem_wdata = cpu_wdata;
            mem_read  = cpu_read & w_cpu_legal;
            mem_write = cpu_write & w_cpu_legal;
            cpu_err   = ~w_cpu_legal;
            cpu_rdata = (cpu_read & w_cpu_legal) ? mem_rdata : '0;
        end else if (w_dbg_gnt) begin
            mem_addr  = dbg_addr;
            mem_wdata = dbg_wdata;
            mem_read  = ~dbg_we & w_dbg_legal;
            mem_write = dbg_we & w_dbg_legal;
            cpu_stall = w_cpu_req;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_dbg_rdata <= '0;
            r_dbg_err   <= 1'b0;
        end else begin
            r_dbg_err   <= w_dbg_gnt & ~w_dbg_legal;
            r_dbg_rdata <= (w_dbg_gnt & ~dbg_we & w_dbg_legal) ? mem_rdata : '0;
        end
    end

    assign dbg_rdata = r_dbg_rdata;
    assign dbg_err   = r_dbg_err;

endmodule
`default_nettype wire

// File: tb/tb_dmem_port_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module : tb_dmem_port_arbiter
// Brief  : Self-checking bench: vector table, directed corner sequences and a
//          randomized run against a transaction-level reference model.
// Rev    : 1.0  initial release
// ============================================================================
module tb_dmem_port_arbiter;

    localparam int DATA_W     = 32;
    localparam int MEM_BYTES  = 128;
    localparam int STARVE_MAX = 4;
    localparam int CNT_W      = 3;
    localparam int N_RAND     = 3000;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              cpu_read, cpu_write;
    logic [DATA_W-1:0] cpu_addr, cpu_wdata, cpu_rdata;
    logic              cpu_stall, cpu_err;
    logic              dbg_req, dbg_we;
    logic [DATA_W-1:0] dbg_addr, dbg_wdata, dbg_rdata;
    logic              dbg_ack, dbg_err;
    logic [DATA_W-1:0] mem_addr, mem_wdata, mem_rdata;
    logic              mem_read, mem_write;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    dmem_port_arbiter #(
        .DATA_W(DATA_W), .MEM_BYTES(MEM_BYTES), .STARVE_MAX(STARVE_MAX), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .cpu_read(cpu_read), .cpu_write(cpu_write), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
        .cpu_err(cpu_err),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr),
        .dbg_wdata(dbg_wdata), .dbg_ack(dbg_ack), .dbg_rdata(dbg_rdata),
        .dbg_err(dbg_err),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_read(mem_read),
        .mem_write(mem_write), .mem_rdata(mem_rdata)
    );

    // Byte-wide big-endian memory, combinational read, negedge write.
    logic [7:0] mem [MEM_BYTES] = '{default: 8'h00};

    always_comb begin
        mem_rdata = '0;
        if (mem_addr <= 32'(MEM_BYTES - 4))
            mem_rdata = {mem[mem_addr[6:0]], mem[mem_addr[6:0] + 7'd1],
                         mem[mem_addr[6:0] + 7'd2], mem[mem_addr[6:0] + 7'd3]};
    end

    always @(negedge clk) begin
        if (mem_write && mem_addr <= 32'(MEM_BYTES - 4)) begin
            mem[mem_addr[6:0]]         = mem_wdata[31:24];
            mem[mem_addr[6:0] + 7'd1]  = mem_wdata[23:16];
            mem[mem_addr[6:0] + 7'd2]  = mem_wdata[15:8];
            mem[mem_addr[6:0] + 7'd3]  = mem_wdata[7:0];
        end
    end

    task automatic chk1(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        cpu_read = 1'b0; cpu_write = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        dbg_req = 1'b0;  dbg_we = 1'b0;    dbg_addr = '0; dbg_wdata = '0;
    endtask

    typedef struct {
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        e_err;
        logic        e_mr;
        logic        e_mw;
        logic [31:0] e_rdata;
    } vec_t;

    vec_t vecs[12];

    // Reference model state: word-indexed shadow memory and handshake progress.
    logic [31:0] shadow [MEM_BYTES/4];
    int          losses;
    bit          d_outstanding, ack_now, prev_stall;
    logic        exp_d_err;
    logic [31:0] exp_d_rdata;

    function automatic bit is_legal(input logic [31:0] a);
        return (a % 4 == 0) && (a + 4 <= MEM_BYTES);
    endfunction

    function automatic logic [31:0] rand_addr();
        if ($urandom_range(0, 9) < 7) return 32'(4 * $urandom_range(0, MEM_BYTES/4 - 1));
        return 32'($urandom_range(0, MEM_BYTES + 7));
    endfunction

    initial begin
        vecs[0]  = '{1'b0, 1'b0, 32'h00, 32'h0,        1'b0, 1'b0, 1'b0, 32'h0};
        vecs[1]  = '{1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 1'b0, 1'b0, 1'b1, 32'h0};
        vecs[2]  = '{1'b1, 1'b0, 32'h10, 32'h0,        1'b0, 1'b1, 1'b0, 32'hDEADBEEF};
        vecs[3]  = '{1'b1, 1'b0, 32'h42, 32'h0,        1'b1, 1'b0, 1'b0, 32'h0};
        vecs[4]  = '{1'b0, 1'b1, 32'h7C, 32'h12345678, 1'b0, 1'b0, 1'b1, 32'h0};
        vecs[5]  = '{1'b1, 1'b0, 32'h7C, 32'h0,        1'b0, 1'b1, 1'b0, 32'h12345678};
        vecs[6]  = '{1'b0, 1'b1, 32'h80, 32'hAAAAAAAA, 1'b1, 1'b0, 1'b0, 32'h0};
        vecs[7]  = '{1'b1, 1'b0, 32'h7D, 32'h0,        1'b1, 1'b0, 1'b0, 32'h0};
        vecs[8]  = '{1'b0, 1'b1, 32'h02, 32'h55555555, 1'b1, 1'b0, 1'b0, 32'h0};
        vecs[9]  = '{1'b1, 1'b0, 32'h7C, 32'h0,        1'b0, 1'b1, 1'b0, 32'h12345678};
        vecs[10] = '{1'b0, 1'b1, 32'h00, 32'h11223344, 1'b0, 1'b0, 1'b1, 32'h0};
        vecs[11] = '{1'b1, 1'b0, 32'h00, 32'h0,        1'b0, 1'b1, 1'b0, 32'h11223344};

        // ---------------- reset state ----------------
        idle_inputs();
        rst_n = 1'b0;
        cpu_read = 1'b1; cpu_addr = 32'h42; dbg_req = 1'b1; dbg_addr = 32'h7D;
        tick(); tick();
        #3;
        chk1("rst_mem_read", mem_read, 1'b0);
        chk1("rst_mem_write", mem_write, 1'b0);
        chk1("rst_cpu_stall", cpu_stall, 1'b0);
        chk1("rst_cpu_err", cpu_err, 1'b0);
        chk1("rst_dbg_ack", dbg_ack, 1'b0);
        chk1("rst_dbg_err", dbg_err, 1'b0);
        chk32("rst_dbg_rdata", dbg_rdata, 32'h0);
        chk32("rst_mem_addr", mem_addr, 32'h0);
        tick();
        idle_inputs();
        rst_n = 1'b1;
        tick();

        // ---------------- CPU-only vector table ----------------
        for (int i = 0; i < 12; i++) begin
            cpu_read = vecs[i].rd; cpu_write = vecs[i].wr;
            cpu_addr = vecs[i].addr; cpu_wdata = vecs[i].wdata;
            #3;
            chk1($sformatf("vec%0d_stall", i), cpu_stall, 1'b0);
            chk1($sformatf("vec%0d_err", i), cpu_err, vecs[i].e_err);
            chk1($sformatf("vec%0d_mem_read", i), mem_read, vecs[i].e_mr);
            chk1($sformatf("vec%0d_mem_write", i), mem_write, vecs[i].e_mw);
            chk32($sformatf("vec%0d_rdata", i), cpu_rdata, vecs[i].e_rdata);
            if (vecs[i].e_mw) chk32($sformatf("vec%0d_wdata", i), mem_wdata, vecs[i].wdata);
            tick();
        end
        idle_inputs();

        // ---------------- debug write alone ----------------
        dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 32'h20; dbg_wdata = 32'hCAFE0001;
        #3;
        chk1("dwr_mem_write", mem_write, 1'b1);
        chk32("dwr_mem_addr", mem_addr, 32'h20);
        chk32("dwr_mem_wdata", mem_wdata, 32'hCAFE0001);
        chk1("dwr_no_ack_yet", dbg_ack, 1'b0);
        tick();
        #3;
        chk1("dwr_ack", dbg_ack, 1'b1);
        chk1("dwr_err", dbg_err, 1'b0);
        chk1("dwr_write_once", mem_write, 1'b0);
        tick();
        dbg_req = 1'b0;
        cpu_read = 1'b1; cpu_addr = 32'h20;
        #3;
        chk1("dwr_ack_pulse", dbg_ack, 1'b0);
        chk32("dwr_readback", cpu_rdata, 32'hCAFE0001);
        tick();
        idle_inputs();

        // ---------------- debug read out of range ----------------
        dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 32'h7D;
        #3;
        chk1("drange_mem_read", mem_read, 1'b0);
        chk1("drange_mem_write", mem_write, 1'b0);
        tick();
        #3;
        chk1("drange_ack", dbg_ack, 1'b1);
        chk1("drange_err", dbg_err, 1'b1);
        chk32("drange_rdata", dbg_rdata, 32'h0);
        tick();
        idle_inputs();

        // ---------------- reset while waiting, then reset in ack cycle ----------------
        dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 32'h30; dbg_wdata = 32'h0BADF00D;
        cpu_read = 1'b1; cpu_addr = 32'h10;
        for (int c = 0; c < 2; c++) begin
            #3;
            chk1($sformatf("rstw_stall%0d", c), cpu_stall, 1'b0);
            tick();
        end
        rst_n = 1'b0; dbg_req = 1'b0;
        #3;
        chk1("rstw_mem_read", mem_read, 1'b0);
        chk1("rstw_stall", cpu_stall, 1'b0);
        tick();
        rst_n = 1'b1; idle_inputs();
        tick();

        dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 32'h24; dbg_wdata = 32'h600DCAFE;
        #3;
        chk1("rsta_grant_write", mem_write, 1'b1);
        tick();
        rst_n = 1'b0; dbg_req = 1'b0; cpu_read = 1'b1; cpu_addr = 32'h10;
        #3;
        chk1("rsta_no_ack", dbg_ack, 1'b0);
        chk1("rsta_mem_read", mem_read, 1'b0);
        chk1("rsta_mem_write", mem_write, 1'b0);
        chk1("rsta_stall", cpu_stall, 1'b0);
        chk32("rsta_mem_addr", mem_addr, 32'h0);
        tick();
        rst_n = 1'b1; idle_inputs();
        #3;
        chk1("rsta_still_no_ack", dbg_ack, 1'b0);
        tick();

        // ---------------- starvation bound (counter must start from 0) ----------------
        cpu_read = 1'b1; cpu_addr = 32'h10;
        dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 32'h20;
        for (int c = 1; c <= STARVE_MAX; c++) begin
            #3;
            chk1($sformatf("starve_c%0d_stall", c), cpu_stall, 1'b0);
            chk32($sformatf("starve_c%0d_addr", c), mem_addr, 32'h10);
            chk32($sformatf("starve_c%0d_rdata", c), cpu_rdata, 32'hDEADBEEF);
            chk1($sformatf("starve_c%0d_ack", c), dbg_ack, 1'b0);
            tick();
        end
        #3;
        chk1("starve_win_stall", cpu_stall, 1'b1);
        chk32("starve_win_addr", mem_addr, 32'h20);
        chk1("starve_win_read", mem_read, 1'b1);
        chk32("starve_win_cpu_rdata", cpu_rdata, 32'h0);
        tick();
        #3;
        chk1("starve_ack", dbg_ack, 1'b1);
        chk32("starve_dbg_rdata", dbg_rdata, 32'hCAFE0001);
        chk1("starve_dbg_err", dbg_err, 1'b0);
        chk1("starve_ack_stall", cpu_stall, 1'b0);
        tick();
        dbg_req = 1'b0; cpu_addr = 32'h30;
        #3;
        chk32("rstw_write_dropped", cpu_rdata, 32'h0);
        tick();
        idle_inputs();

        // ---------------- randomized run against the reference model ----------------
        for (int w = 0; w < MEM_BYTES/4; w++)
            shadow[w] = {mem[4*w], mem[4*w+1], mem[4*w+2], mem[4*w+3]};
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        losses = 0; d_outstanding = 0; ack_now = 0; prev_stall = 0;
        exp_d_err = 1'b0; exp_d_rdata = '0;

        for (int cyc = 0; cyc < N_RAND; cyc++) begin
            bit          elig, d_wins, c_wins, c_req, leg, ack_next;
            logic        e_mr, e_mw, e_err, e_stall;
            logic [31:0] e_addr, e_wdata, e_crdata;

            if (!prev_stall) begin
                case ($urandom_range(0, 4))
                    0, 1:    begin cpu_read = 1'b0; cpu_write = 1'b0; end
                    2, 3:    begin cpu_read = 1'b1; cpu_write = 1'b0; end
                    default: begin cpu_read = 1'b0; cpu_write = 1'b1; end
                endcase
                cpu_addr = rand_addr(); cpu_wdata = $urandom;
            end
            if (!dbg_req) begin
                if ($urandom_range(0, 1) == 1) begin
                    dbg_req = 1'b1; dbg_we = 1'($urandom_range(0, 1));
                    dbg_addr = rand_addr(); dbg_wdata = $urandom;
                end
            end else if (ack_now && $urandom_range(0, 3) != 0) begin
                dbg_req = 1'b0;
            end

            // Expected arbitration outcome from the priority/starvation rules.
            c_req  = cpu_read | cpu_write;
            elig   = !ack_now && (d_outstanding || dbg_req);
            d_wins = elig && (!c_req || losses == STARVE_MAX);
            c_wins = c_req && !d_wins;
            e_mr = 0; e_mw = 0; e_err = 0; e_stall = 0;
            e_addr = '0; e_wdata = '0; e_crdata = '0;
            if (c_wins) begin
                leg = is_legal(cpu_addr);
                e_addr = cpu_addr; e_wdata = cpu_wdata;
                e_mr = cpu_read && leg; e_mw = cpu_write && leg; e_err = !leg;
                if (cpu_read && leg) e_crdata = shadow[cpu_addr / 4];
            end else if (d_wins) begin
                leg = is_legal(dbg_addr);
                e_addr = dbg_addr; e_wdata = dbg_wdata;
                e_mr = !dbg_we && leg; e_mw = dbg_we && leg; e_stall = c_req;
            end

            #3;
            chk1("rnd_stall", cpu_stall, e_stall);
            chk1("rnd_cpu_err", cpu_err, e_err);
            chk1("rnd_mem_read", mem_read, e_mr);
            chk1("rnd_mem_write", mem_write, e_mw);
            chk32("rnd_cpu_rdata", cpu_rdata, e_crdata);
            if (e_mr || e_mw) chk32("rnd_mem_addr", mem_addr, e_addr);
            if (e_mw) chk32("rnd_mem_wdata", mem_wdata, e_wdata);
            chk1("rnd_dbg_ack", dbg_ack, ack_now);
            if (ack_now) begin
                chk1("rnd_dbg_err", dbg_err, exp_d_err);
                chk32("rnd_dbg_rdata", dbg_rdata, exp_d_rdata);
            end

            ack_next = 0;
            if (c_wins && cpu_write && is_legal(cpu_addr)) shadow[cpu_addr / 4] = cpu_wdata;
            if (d_wins) begin
                leg = is_legal(dbg_addr);
                ack_next = 1; d_outstanding = 0; losses = 0;
                exp_d_err = !leg;
                exp_d_rdata = (!dbg_we && leg) ? shadow[dbg_addr / 4] : 32'h0;
                if (dbg_we && leg) shadow[dbg_addr / 4] = dbg_wdata;
            end else if (elig) begin
                d_outstanding = 1;
                losses = (losses < STARVE_MAX) ? losses + 1 : STARVE_MAX;
            end
            ack_now = ack_next;
            prev_stall = c_req && d_wins;
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
